// File: rtl/alu16_seq.sv
// Sequencer that runs 16-bit ADD HL,rr / ADD SP,e8 / SUB16 through an external
// 8-bit ALU as a low-byte pass then a high-byte pass, and collects SM83 flags.
module alu16_seq (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  output logic        alu_sub,
  input  logic [7:0]  alu_res,
  input  logic        alu_cout,
  input  logic        alu_hout,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        f_z,
  output logic        f_n,
  output logic        f_h,
  output logic        f_c,
  output logic [3:0]  f_wr
);

  localparam logic [1:0] OP_ADD16 = 2'b00;
  localparam logic [1:0] OP_ADDSP = 2'b01;
  localparam logic [1:0] OP_SUB16 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_p0;
  logic [15:0] opa_p0;
  logic [15:0] opb_p0;
  logic        carry_lo_p1;
  logic        h_lo_p1;

  // The reserved encoding behaves exactly like ADD16, so fold it at latch time.
  function automatic logic [1:0] norm_op(input logic [1:0] o);
    return (o == 2'b11) ? OP_ADD16 : o;
  endfunction

  function automatic logic [7:0] sext_hi(input logic signed [7:0] e8);
    logic signed [15:0] wide;
    wide = 16'(e8);
    return wide[15:8];
  endfunction

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_cin   = 1'b0;
    alu_sub   = 1'b0;
    done      = 1'b0;
    f_wr      = 4'b0000;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LO;
      end
      S_LO: begin
        alu_a     = opa_p0[7:0];
        alu_b     = opb_p0[7:0];
        alu_sub   = (op_p0 == OP_SUB16);
        state_nxt = S_HI;
      end
      S_HI: begin
        alu_a     = opa_p0[15:8];
        alu_b     = (op_p0 == OP_ADDSP) ? sext_hi(opb_p0[7:0]) : opb_p0[15:8];
        alu_cin   = carry_lo_p1;
        alu_sub   = (op_p0 == OP_SUB16);
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        f_wr      = (op_p0 == OP_ADD16) ? 4'b0111 : 4'b1111;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- p0: operand capture / p1: low-byte pass / p2: high-byte pass + flags ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      op_p0       <= 2'b00;
      opa_p0      <= 16'h0000;
      opb_p0      <= 16'h0000;
      result      <= 16'h0000;
      carry_lo_p1 <= 1'b0;
      h_lo_p1     <= 1'b0;
      f_z         <= 1'b0;
      f_n         <= 1'b0;
      f_h         <= 1'b0;
      f_c         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_p0  <= norm_op(op);
            opa_p0 <= opa;
            opb_p0 <= opb;
          end
        end
        S_LO: begin
          result[7:0] <= alu_res;
          carry_lo_p1 <= alu_cout;
          h_lo_p1     <= alu_hout;
        end
        S_HI: begin
          result[15:8] <= alu_res;
          case (op_p0)
            // SP+e8 reports the byte-level carries from the low pass.
            OP_ADDSP: begin
              f_z <= 1'b0;
              f_n <= 1'b0;
              f_h <= h_lo_p1;
              f_c <= carry_lo_p1;
            end
            OP_SUB16: begin
              f_z <= ({alu_res, result[7:0]} == 16'h0000);
              f_n <= 1'b1;
              f_h <= alu_hout;
              f_c <= alu_cout;
            end
            default: begin
              f_z <= 1'b0;
              f_n <= 1'b0;
              f_h <= alu_hout;
              f_c <= alu_cout;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: an 8-bit ALU model closes the loop, and a 16-bit
// arithmetic reference model predicts result, flags and per-pass ALU drive.
module tb_alu16_seq;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa, opb;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic        alu_cin, alu_sub, alu_cout, alu_hout;
  logic        busy, done;
  logic [15:0] result;
  logic        f_z, f_n, f_h, f_c;
  logic [3:0]  f_wr;

  int checks = 0;
  int errors = 0;

  alu16_seq dut (
    .clk(clk), .nreset(nreset), .start(start), .op(op), .opa(opa), .opb(opb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sub(alu_sub),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_hout(alu_hout),
    .busy(busy), .done(done), .result(result),
    .f_z(f_z), .f_n(f_n), .f_h(f_h), .f_c(f_c), .f_wr(f_wr)
  );

  always #5 clk = ~clk;

  // Downstream 8-bit ALU: add with carry, or subtract with borrow.
  logic [8:0] t9;
  logic [4:0] t5;
  always_comb begin
    t9 = 9'd0;
    t5 = 5'd0;
    if (alu_sub) begin
      t9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      t5 = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'd0, alu_cin};
    end else begin
      t9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      t5 = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, alu_cin};
    end
  end
  assign alu_res  = t9[7:0];
  assign alu_cout = t9[8];
  assign alu_hout = t5[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: flags derived from 16-bit arithmetic on the operands.
  task automatic model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [3:0] fl,
                       output logic [3:0] wr, output logic clo);
    logic [15:0] e;
    logic z, n, h, c;
    case (o)
      2'b10: begin
        r = a - b;
        c = (a < b);
        h = (a[11:0] < b[11:0]);
        z = (r == 16'h0000);
        n = 1'b1;
        wr = 4'b1111;
        clo = (a[7:0] < b[7:0]);
      end
      2'b01: begin
        e = {{8{b[7]}}, b[7:0]};
        r = a + e;
        c = (int'(a[7:0]) + int'(b[7:0])) > 255;
        h = (int'(a[3:0]) + int'(b[3:0])) > 15;
        z = 1'b0;
        n = 1'b0;
        wr = 4'b1111;
        clo = c;
      end
      default: begin
        r = a + b;
        c = (int'(a) + int'(b)) > 65535;
        h = (int'(a[11:0]) + int'(b[11:0])) > 4095;
        z = 1'b0;
        n = 1'b0;
        wr = 4'b0111;
        clo = (int'(a[7:0]) + int'(b[7:0])) > 255;
      end
    endcase
    fl = {z, n, h, c};
  endtask

  task automatic scramble();
    op  = 2'($urandom_range(0, 3));
    opa = 16'($urandom);
    opb = 16'($urandom);
  endtask

  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input bit hold);
    logic [15:0] r;
    logic [3:0]  fl, wr;
    logic        clo;
    logic [7:0]  bhi;
    model(o, a, b, r, fl, wr, clo);
    bhi = (o == 2'b01) ? {8{b[7]}} : b[15:8];
    check("idle_busy", 32'(busy), 32'(0));
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    if (!hold) start = 1'b0;
    scramble();
    check("lo_busy", 32'(busy), 32'(1));
    check("lo_done", 32'(done), 32'(0));
    check("lo_alu_a", 32'(alu_a), 32'(a[7:0]));
    check("lo_alu_b", 32'(alu_b), 32'(b[7:0]));
    check("lo_alu_cin", 32'(alu_cin), 32'(0));
    check("lo_alu_sub", 32'(alu_sub), 32'(o == 2'b10));
    @(negedge clk);
    scramble();
    check("hi_alu_a", 32'(alu_a), 32'(a[15:8]));
    check("hi_alu_b", 32'(alu_b), 32'(bhi));
    check("hi_alu_cin", 32'(alu_cin), 32'(clo));
    check("hi_alu_sub", 32'(alu_sub), 32'(o == 2'b10));
    check("hi_done", 32'(done), 32'(0));
    @(negedge clk);
    scramble();
    check("done_pulse", 32'(done), 32'(1));
    check("done_busy", 32'(busy), 32'(1));
    check("done_result", 32'(result), 32'(r));
    check("done_flags", 32'({f_z, f_n, f_h, f_c}), 32'(fl));
    check("done_fwr", 32'(f_wr), 32'(wr));
    check("done_alu_a", 32'(alu_a), 32'(0));
    @(negedge clk);
    check("post_done", 32'(done), 32'(0));
    check("post_fwr", 32'(f_wr), 32'(0));
    check("post_busy", 32'(busy), 32'(0));
    check("post_result", 32'(result), 32'(r));
    check("post_flags", 32'({f_z, f_n, f_h, f_c}), 32'(fl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; start = 1'b0; op = 2'b00; opa = 16'h0000; opb = 16'h0000;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_flags", 32'({f_z, f_n, f_h, f_c}), 32'(0));
    check("rst_fwr", 32'(f_wr), 32'(0));
    check("rst_alu", 32'({alu_a, alu_b, alu_cin, alu_sub}), 32'(0));
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    do_op(2'b00, 16'h0FFF, 16'h0001, 1'b0);
    do_op(2'b00, 16'hFFFF, 16'h0001, 1'b0);
    do_op(2'b01, 16'hFFF8, 16'h0008, 1'b0);
    do_op(2'b01, 16'h0005, 16'h00FE, 1'b0);
    do_op(2'b10, 16'h1000, 16'h0001, 1'b0);
    do_op(2'b10, 16'h1234, 16'h1234, 1'b0);
    do_op(2'b10, 16'h0000, 16'h0001, 1'b0);
    do_op(2'b11, 16'h8000, 16'h8000, 1'b0);

    // start held high across back-to-back operations
    for (int i = 0; i < 6; i++)
      do_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'b1);
    start = 1'b0;

    // reset pulse while the high-byte pass is in flight
    start = 1'b1; op = 2'b10; opa = 16'h1234; opb = 16'h4321;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_result", 32'(result), 32'(0));
    check("abort_flags", 32'({f_z, f_n, f_h, f_c}), 32'(0));
    check("abort_fwr", 32'(f_wr), 32'(0));
    check("abort_alu", 32'({alu_a, alu_b, alu_cin, alu_sub}), 32'(0));
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'(0));
      check("abort_idle", 32'(busy), 32'(0));
    end
    do_op(2'b00, 16'h1234, 16'h4321, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
      start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
